gat_feat_readout: RTL and testbench
===================================

// Module: gat_feat_readout
// PURPOSE
//  Downstream drain stage of the GAT accelerator top: after gat_ready rises, walks the final-feature BRAM
//  (byte-addressed port B, word index in addr[ADDR_W+1:2]) from word 0 to NEW_FEATURE_DEPTH-1.
//  Re-emits every word as a valid/ready stream with per-subgraph and end-of-frame markers toward the host DMA.
//  Credit-based issue plus a small FIFO absorbs BRAM read latency under arbitrary backpressure.
// PARAMETERS
//  NEW_FEATURE_WIDTH   32     width of one output feature word
//  NUM_SUBGRAPHS       2708   subgraphs in the result
//  NUM_FEATURE_OUT     16     feature words per subgraph
//  NEW_FEATURE_DEPTH   NUM_SUBGRAPHS*NUM_FEATURE_OUT   total words (local)
//  NEW_FEATURE_ADDR_W  $clog2(NEW_FEATURE_DEPTH)       word-index width (local)
//  RD_LATENCY          2      cycles from feat_bram_addrb registered to feat_bram_dout valid (1..4)
//  FIFO_DEPTH          4      output FIFO entries, power of 2, >= RD_LATENCY+2
// PORTS
//  clk               in   1                     clock
//  rst               in   1                     asynchronous reset, active-high
//  gat_ready         in   1                     accelerator finished; rising edge arms one readout
//  feat_bram_addrb   out  NEW_FEATURE_ADDR_W+2  byte address to feature BRAM, low 2 bits always 0
//  feat_bram_dout    in   NEW_FEATURE_WIDTH     BRAM read data, RD_LATENCY after address
//  m_tdata           out  NEW_FEATURE_WIDTH     feature word
//  m_tvalid          out  1                     word valid
//  m_tready          in   1                     consumer accepts when m_tvalid&m_tready
//  m_tuser           out  1                     1 on first word of each subgraph (index % NUM_FEATURE_OUT == 0)
//  m_tlast           out  1                     1 on word NEW_FEATURE_DEPTH-1 only
//  busy              out  1                     1 in READ or DRAIN
//  done              out  1                     level: full frame delivered; cleared when gat_ready falls
// BEHAVIOUR
//  - Reset: all outputs 0, addrb=0, FIFO empty, in-flight pipe cleared, state IDLE. Reset mid-frame discards
//    everything; next frame needs a fresh gat_ready rising edge (edge detector register also reset to 0).
//  - FSM: IDLE -(gat_ready 0->1)-> READ -(last address issued)-> DRAIN -(last word popped)-> DONE
//    -(gat_ready==0)-> IDLE. Edges seen outside IDLE are ignored; gat_ready falling mid-frame does not abort.
//  - Issue: in READ, one read per cycle when credit: fifo_count + inflight < FIFO_DEPTH (inflight counts
//    reads issued but not yet returned, 0..RD_LATENCY). addrb = rd_idx<<2, registered; rd_idx 0..DEPTH-1, no wrap.
//  - Return: RD_LATENCY-deep valid shift register tagged with tuser/tlast; dout pushed to FIFO on tag-valid.
//    Credit rule guarantees no overflow; a push into a full FIFO is an assertion failure.
//  - Output: m_tvalid = !fifo_empty; data/user/last from FIFO head; pop on m_tvalid&m_tready; simultaneous
//    push and pop allowed at any occupancy incl. full. m_tdata/user/last stable while m_tvalid&!m_tready.
//  - Zero-bubble: with m_tready held 1, first word at m_tvalid RD_LATENCY+2 cycles after the gat_ready edge
//    (1 edge detect, 1 addr reg, RD_LATENCY); thereafter one word per cycle.
//  - done rises the cycle after the tlast handshake; busy falls same cycle. NEW_FEATURE_DEPTH==1: first word has
//    tuser=tlast=1.
//  - Counters: rd_idx and wr tag index NEW_FEATURE_ADDR_W bits; subgraph-position counter $clog2(NUM_FEATURE_OUT)
//    bits, wraps at NUM_FEATURE_OUT-1 (not power-of-2 safe via compare, not mask).
// STRUCTURE
//  - Shared package gat_pkg: NEW_FEATURE_DEPTH/ADDR_W derivation, feat_rd_state_t enum {IDLE,READ,DRAIN,DONE},
//    feat_word_t struct {data,user,last}.
//  - One sub-module: gat_sync_fifo (width/depth params, count output, full/empty); rest inline.
// TESTING (small config: NUM_SUBGRAPHS=3, NUM_FEATURE_OUT=4 -> 12 words, RD_LATENCY=2, FIFO_DEPTH=4;
//          BRAM model returns 0xA000_0000+index)
//  1 Free flow: m_tready=1, gat_ready 0->1 at T -> first m_tvalid at T+4, 12 consecutive beats 0xA0000000..0xA000000B,
//    tuser on idx 0,4,8, tlast on idx 11 only, done=1 at beat11+1, addrb max 0x2C.
//  2 Backpressure: m_tready random 30% -> identical ordered sequence, no drop/dup, FIFO never overflows,
//    data held stable while stalled, addrb advances only with credit.
//  3 Full stall: m_tready=0 for 20 cycles after start -> exactly 4 reads issued (addrb 0x0..0xC), then release
//    -> all 12 words delivered in order.
//  4 Re-arm: hold gat_ready=1 after done -> no second frame; drop to 0 -> IDLE, done=0; raise again -> second
//    identical 12-word frame.
//  5 Reset mid-frame: assert rst after beat 5 -> all outputs 0 next cycle; release, pulse gat_ready -> frame
//    restarts at 0xA0000000; gat_ready falling mid-frame (no rst) -> frame still completes.

Source files
------------

// File: rtl/gat_pkg.sv
// Shared types and size helpers for the GAT accelerator readout path.
// Holds the readout FSM state encoding and the word format carried through the output FIFO.
package gat_pkg;

   localparam int FEAT_WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } feat_rd_state_t;

   typedef struct packed {
      logic [FEAT_WORD_W-1:0] data;
      logic                   user;
      logic                   last;
   } feat_word_t;

   function automatic int feat_depth(input int num_subgraphs, input int num_feature_out);
      return num_subgraphs * num_feature_out;
   endfunction

   // Counters must keep at least one bit even when they only ever hold 0.
   function automatic int clog2_min1(input int value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

endpackage

// File: rtl/gat_sync_fifo.sv
// Single-clock FIFO with occupancy count; simultaneous push and pop are legal at any fill level.
// DEPTH must be a power of two so the pointers wrap on their own.
module gat_sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // NOTE: storage has no reset; only pointers and count do, and consumers never read an empty slot.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/gat_feat_readout.sv
// Drains the final-feature BRAM as a valid/ready stream with subgraph (tuser) and frame (tlast) markers.
// Reads are issued only against FIFO credit, so BRAM latency never overruns the output buffer.
module gat_feat_readout
   import gat_pkg::*;
#(
   parameter  int NEW_FEATURE_WIDTH  = FEAT_WORD_W,
   parameter  int NUM_SUBGRAPHS      = 2708,
   parameter  int NUM_FEATURE_OUT    = 16,
   parameter  int RD_LATENCY         = 2,
   parameter  int FIFO_DEPTH         = 4,
   localparam int NEW_FEATURE_DEPTH  = feat_depth(NUM_SUBGRAPHS, NUM_FEATURE_OUT),
   localparam int NEW_FEATURE_ADDR_W = clog2_min1(NEW_FEATURE_DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          gat_ready,
   output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
   input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
   output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic                          m_tuser,
   output logic                          m_tlast,
   output logic                          busy,
   output logic                          done
);

   localparam int AW  = NEW_FEATURE_ADDR_W;
   localparam int SPW = clog2_min1(NUM_FEATURE_OUT);
   localparam int FCW = $clog2(FIFO_DEPTH) + 1;

   localparam logic [AW-1:0]  LAST_IDX  = AW'(NEW_FEATURE_DEPTH - 1);
   localparam logic [SPW-1:0] SUB_LAST  = SPW'(NUM_FEATURE_OUT - 1);
   localparam logic [FCW:0]   FIFO_LIM  = (FCW + 1)'(FIFO_DEPTH);

   feat_rd_state_t state, state_nx;

   logic                  gat_ready_q;
   logic [AW-1:0]         rd_idx;
   logic [SPW-1:0]        sub_pos;
   logic [FCW-1:0]        inflight;
   logic [RD_LATENCY-1:0] tag_vld;
   logic [RD_LATENCY-1:0] tag_user;
   logic [RD_LATENCY-1:0] tag_last;

   logic                  issue;
   logic                  credit_ok;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [FCW-1:0]        fifo_count;
   feat_word_t            fifo_wdata;
   feat_word_t            fifo_head;

   assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < FIFO_LIM;
   assign issue     = (state == READ) && credit_ok;
   assign fifo_push = tag_vld[RD_LATENCY-1];
   assign fifo_pop  = m_tvalid && m_tready;

   assign fifo_wdata = '{data: feat_bram_dout,
                         user: tag_user[RD_LATENCY-1],
                         last: tag_last[RD_LATENCY-1]};

   gat_sync_fifo #(
      .WIDTH ($bits(feat_word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (fifo_wdata),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Head fields are masked while empty so unreset FIFO storage never reaches the port.
   assign m_tvalid = !fifo_empty;
   assign m_tdata  = fifo_empty ? '0   : fifo_head.data;
   assign m_tuser  = fifo_empty ? 1'b0 : fifo_head.user;
   assign m_tlast  = fifo_empty ? 1'b0 : fifo_head.last;
   assign busy     = (state == READ) || (state == DRAIN);
   assign done     = (state == DONE);

   // NOTE: state_nx gets its default first so no path through the case leaves it unassigned (no latch).
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (gat_ready && !gat_ready_q)       state_nx = READ;
         READ:    if (issue && (rd_idx == LAST_IDX))   state_nx = DRAIN;
         DRAIN:   if (fifo_pop && fifo_head.last)      state_nx = DONE;
         DONE:    if (!gat_ready)                      state_nx = IDLE;
         default:                                      state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         gat_ready_q     <= 1'b0;
         rd_idx          <= '0;
         sub_pos         <= '0;
         inflight        <= '0;
         feat_bram_addrb <= '0;
         tag_vld         <= '0;
         tag_user        <= '0;
         tag_last        <= '0;
      end else begin
         state       <= state_nx;
         gat_ready_q <= gat_ready;
         inflight    <= inflight + FCW'(issue) - FCW'(fifo_push);

         if (state == IDLE) begin
            rd_idx  <= '0;
            sub_pos <= '0;
         end else if (issue) begin
            feat_bram_addrb <= {rd_idx, 2'b00};
            if (rd_idx != LAST_IDX) rd_idx <= rd_idx + AW'(1);
            sub_pos <= (sub_pos == SUB_LAST) ? '0 : sub_pos + SPW'(1);
         end

         // Tags ride alongside the read so they line up with the returning BRAM word.
         tag_vld[0]  <= issue;
         tag_user[0] <= issue && (sub_pos == '0);
         tag_last[0] <= issue && (rd_idx == LAST_IDX);
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_vld[i]  <= tag_vld[i-1];
            tag_user[i] <= tag_user[i-1];
            tag_last[i] <= tag_last[i-1];
         end
      end
   end

   no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
      !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_gat_feat_readout.sv
// Directed bench for gat_feat_readout (3 subgraphs x 4 words, RD_LATENCY 2, FIFO 4).
// A per-cycle compare process checks every offered beat against the expected frame contents.
module tb_gat_feat_readout;

   localparam int NS  = 3;
   localparam int NFO = 4;
   localparam int L   = 2;
   localparam int FD  = 4;
   localparam int N   = NS * NFO;
   localparam int AW  = $clog2(N);
   localparam int W   = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          gat_ready;
   logic [AW+1:0] feat_bram_addrb;
   logic [W-1:0]  feat_bram_dout;
   logic [W-1:0]  m_tdata;
   logic          m_tvalid;
   logic          m_tready;
   logic          m_tuser;
   logic          m_tlast;
   logic          busy;
   logic          done;

   int tests = 0;
   int fails = 0;
   int beat  = 0;
   bit rand_ready = 1'b0;

   always #5 clk = ~clk;

   gat_feat_readout #(
      .NEW_FEATURE_WIDTH (W),
      .NUM_SUBGRAPHS     (NS),
      .NUM_FEATURE_OUT   (NFO),
      .RD_LATENCY        (L),
      .FIFO_DEPTH        (FD)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .gat_ready       (gat_ready),
      .feat_bram_addrb (feat_bram_addrb),
      .feat_bram_dout  (feat_bram_dout),
      .m_tdata         (m_tdata),
      .m_tvalid        (m_tvalid),
      .m_tready        (m_tready),
      .m_tuser         (m_tuser),
      .m_tlast         (m_tlast),
      .busy            (busy),
      .done            (done)
   );

   // BRAM: address captured one edge after addrb is registered, data sampled by the DUT on the next.
   logic [W-1:0] bram_q = '0;
   always @(posedge clk) bram_q <= 32'hA000_0000 + 32'(feat_bram_addrb >> 2);
   assign feat_bram_dout = bram_q;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [33:0] exp_word(input int idx);
      return {32'hA000_0000 + 32'(idx), (idx % NFO) == 0, idx == N - 1};
   endfunction

   // Compare process: frame contents, ordering, hold-while-stalled, outstanding-read bound.
   logic [34:0] held;
   bit          stalled = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         check("reset_outputs", {m_tvalid, m_tdata, m_tuser, m_tlast, busy, done, feat_bram_addrb}, '0);
         beat    = 0;
         stalled = 1'b0;
      end else begin
         if (stalled) check("hold_while_stalled", {m_tvalid, m_tdata, m_tuser, m_tlast}, held);
         stalled = 1'b0;
         if (m_tvalid) begin
            if (beat >= N) check("extra_beat", 64'(beat), 64'(N - 1));
            else check($sformatf("beat%0d", beat), {m_tdata, m_tuser, m_tlast}, exp_word(beat));
            if (beat > 0)
               check("outstanding_reads", 64'((int'(feat_bram_addrb >> 2) + 1 - beat) <= FD), 64'd1);
            if (m_tready) beat++;
            else begin
               stalled = 1'b1;
               held    = {m_tvalid, m_tdata, m_tuser, m_tlast};
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) m_tready = ($urandom_range(0, 99) >= 30);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic arm();
      gat_ready = 1'b0;
      repeat (2) tick();
      beat      = 0;
      gat_ready = 1'b1;
   endtask

   task automatic wait_done(input string name, input int budget);
      for (int c = 0; c < budget; c++) begin
         tick();
         if (done) break;
      end
      check({name, "_done"}, done, 1'b1);
      check({name, "_count"}, 64'(beat), 64'(N));
   endtask

   initial begin
      int c;
      rst       = 1'b0;
      gat_ready = 1'b0;
      m_tready  = 1'b0;
      #2 rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // 1: free flow, latency and zero-bubble streaming
      m_tready = 1'b1;
      arm();
      check("idle_before_edge", busy, 1'b0);
      for (c = 1; c <= 20; c++) begin
         tick();
         if (m_tvalid) break;
      end
      check("first_latency", 64'(c), 64'd4);
      check("first_data", m_tdata, 32'hA000_0000);
      check("first_tuser", m_tuser, 1'b1);
      check("busy_in_frame", busy, 1'b1);
      for (int i = 0; i < N; i++) begin
         check($sformatf("no_bubble%0d", i), m_tvalid, 1'b1);
         if (i == N - 1) begin
            check("last_data", m_tdata, 32'hA000_000B);
            check("last_tlast", m_tlast, 1'b1);
         end
         tick();
      end
      check("done_after_tlast", done, 1'b1);
      check("busy_after_tlast", busy, 1'b0);
      check("addrb_max", feat_bram_addrb, 6'h2C);

      // 4: re-arm needs gat_ready to fall first
      repeat (10) tick();
      check("hold_done", done, 1'b1);
      check("no_second_frame", m_tvalid, 1'b0);
      gat_ready = 1'b0;
      tick();
      check("done_cleared", done, 1'b0);
      arm();
      wait_done("rearm", 100);

      // 2: random backpressure
      rand_ready = 1'b1;
      arm();
      wait_done("backpressure", 400);
      rand_ready = 1'b0;

      // 3: full stall after start
      m_tready = 1'b0;
      arm();
      repeat (20) tick();
      check("stall_addrb", feat_bram_addrb, 6'h0C);
      check("stall_head", m_tdata, 32'hA000_0000);
      m_tready = 1'b1;
      wait_done("stall_release", 100);

      // 5: reset mid-frame, then restart
      arm();
      for (c = 0; c < 100; c++) begin
         tick();
         if (beat >= 6) break;
      end
      check("reached_beat6", 64'(beat >= 6), 64'd1);
      rst       = 1'b1;
      gat_ready = 1'b0;
      #1;
      check("rst_mid_outputs", {m_tvalid, m_tdata, m_tuser, m_tlast, busy, done, feat_bram_addrb}, '0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (3) tick();
      check("idle_after_rst", {busy, m_tvalid}, 2'b00);
      arm();
      for (c = 1; c <= 20; c++) begin
         tick();
         if (m_tvalid) break;
      end
      check("restart_data", m_tdata, 32'hA000_0000);
      wait_done("restart", 100);

      // gat_ready falling mid-frame does not abort
      arm();
      repeat (6) tick();
      gat_ready = 1'b0;
      wait_done("ready_fall", 100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
